// File: rtl/adder_err_pkg.sv
// Shared definitions for the approximate-adder error monitor.
// Holds the run-control state encoding and the width constants that the
// interface and the top level derive their buses from.
package adder_err_pkg;

  localparam int WIDTH = 16;                // operand width
  localparam int CNT_W = 32;                // sample / error counter width
  localparam int SUM_W = WIDTH + 1;         // width of exact and approximate sums
  localparam int ACC_W = WIDTH + 1 + CNT_W; // sum of |error| can never overflow

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_err_if.sv
// Bus between the sample source / result reader and adder_err_monitor.
// master: drives run control and samples, reads results.
// slave : the monitor itself.
//   start, num_samples          run control (start is a one-cycle pulse)
//   in_valid/in_ready           sample handshake
//   op_a, op_b, approx_sum      one sample from the adder under evaluation
//   busy, done                  run status
//   err_count, sum_abs_err,
//   max_abs_err, worst_a/b      accumulated error metrics
interface adder_err_if;

  logic                             start;
  logic [adder_err_pkg::CNT_W-1:0]  num_samples;
  logic                             in_valid;
  logic                             in_ready;
  logic [adder_err_pkg::WIDTH-1:0]  op_a;
  logic [adder_err_pkg::WIDTH-1:0]  op_b;
  logic [adder_err_pkg::SUM_W-1:0]  approx_sum;
  logic                             busy;
  logic                             done;
  logic [adder_err_pkg::CNT_W-1:0]  err_count;
  logic [adder_err_pkg::ACC_W-1:0]  sum_abs_err;
  logic [adder_err_pkg::SUM_W-1:0]  max_abs_err;
  logic [adder_err_pkg::WIDTH-1:0]  worst_a;
  logic [adder_err_pkg::WIDTH-1:0]  worst_b;

  modport master (
    output start, num_samples, in_valid, op_a, op_b, approx_sum,
    input  in_ready, busy, done, err_count, sum_abs_err, max_abs_err,
           worst_a, worst_b
  );

  modport slave (
    input  start, num_samples, in_valid, op_a, op_b, approx_sum,
    output in_ready, busy, done, err_count, sum_abs_err, max_abs_err,
           worst_a, worst_b
  );

endinterface

// File: rtl/adder_err_calc.sv
// Combinational error arithmetic for one sample of an OPW-bit adder.
//   op_a, op_b   in   operands
//   approx_sum   in   approximate adder result (OPW+1 bits)
//   abs_err      out  |(op_a + op_b) - approx_sum|, OPW+1 bits
//   is_err       out  approximate result differs from the exact sum
module adder_err_calc #(
  parameter int OPW = 16
) (
  input  logic [OPW-1:0] op_a,
  input  logic [OPW-1:0] op_b,
  input  logic [OPW:0]   approx_sum,
  output logic [OPW:0]   abs_err,
  output logic           is_err
);

  logic        [OPW:0]   exact;
  logic signed [OPW+1:0] diff;

  assign exact  = {1'b0, op_a} + {1'b0, op_b};
  // One extra bit keeps the difference of two unsigned OPW+1-bit values
  // representable as signed; its magnitude always fits back in OPW+1 bits.
  assign diff    = $signed({1'b0, exact}) - $signed({1'b0, approx_sum});
  assign abs_err = diff[OPW+1] ? (OPW+1)'(-diff) : (OPW+1)'(diff);
  assign is_err  = (exact != approx_sum);

endmodule

// File: rtl/adder_err_monitor.sv
// Streaming error-metric accumulator for a 16-bit approximate adder.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave side of adder_err_if (run control, samples, results)
// Accepted samples pass through two stages: stage 1 registers the operands
// and the error arithmetic, stage 2 folds them into the accumulators.
// After the last accept the block drains for two cycles, then holds DONE.
module adder_err_monitor
  import adder_err_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  adder_err_if.slave bus
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   num_lat;
  logic [CNT_W-1:0]   accepted;
  logic               drain_cnt;
  logic               in_ready, busy, done;
  logic               accept, go, last;

  logic [SUM_W-1:0]   calc_abs;
  logic               calc_err;

  logic               s1_valid, s1_err;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic [SUM_W-1:0]   s1_abs;

  logic [CNT_W-1:0]   err_count;
  logic [ACC_W-1:0]   sum_abs_err;
  logic [SUM_W-1:0]   max_abs_err;
  logic [WIDTH-1:0]   worst_a, worst_b;

  adder_err_calc #(.OPW(WIDTH)) u_calc (
    .op_a       (bus.op_a),
    .op_b       (bus.op_b),
    .approx_sum (bus.approx_sum),
    .abs_err    (calc_abs),
    .is_err     (calc_err)
  );

  assign accept = bus.in_valid && in_ready;
  assign go     = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last   = accept && ((accepted + CNT_W'(1)) == num_lat);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx is defaulted first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = (bus.num_samples == '0) ? DONE : RUN;
      RUN:        if (last)      state_nx = DRAIN;
      DRAIN:      if (drain_cnt) state_nx = DONE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Handshake and status depend on registered state only.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        busy     = 1'b1;
        in_ready = (accepted < num_lat);
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Run bookkeeping and both pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_lat     <= '0;
      accepted    <= '0;
      drain_cnt   <= 1'b0;
      s1_valid    <= 1'b0;
      s1_err      <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_abs      <= '0;
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
    end else begin
      // Two-cycle drain: 0 on the first DRAIN cycle, 1 on the second.
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (go) begin
        num_lat     <= bus.num_samples;
        accepted    <= '0;
        s1_valid    <= 1'b0;
        err_count   <= '0;
        sum_abs_err <= '0;
        max_abs_err <= '0;
        worst_a     <= '0;
        worst_b     <= '0;
      end else begin
        accepted <= accepted + CNT_W'(accept);
        s1_valid <= accept;
        if (accept) begin
          s1_a   <= bus.op_a;
          s1_b   <= bus.op_b;
          s1_abs <= calc_abs;
          s1_err <= calc_err;
        end
        if (s1_valid) begin
          err_count   <= err_count + CNT_W'(s1_err);
          sum_abs_err <= sum_abs_err + ACC_W'(s1_abs);
          // Strictly greater: on a tie the earlier sample stays the worst.
          if (s1_abs > max_abs_err) begin
            max_abs_err <= s1_abs;
            worst_a     <= s1_a;
            worst_b     <= s1_b;
          end
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.err_count   = err_count;
  assign bus.sum_abs_err = sum_abs_err;
  assign bus.max_abs_err = max_abs_err;
  assign bus.worst_a     = worst_a;
  assign bus.worst_b     = worst_b;

endmodule

// File: doc/adder_err_monitor.md
# adder_err_monitor

Streaming error-metric accumulator placed directly downstream of the 16-bit approximate adder under evaluation. Each accepted sample carries the two operands and the approximate adder's 17-bit sum. The block computes the exact sum internally and accumulates error count, sum of absolute error, and maximum absolute error, together with the operands that produced that maximum. A run covers a programmed number of samples and ends with results held stable for readout.

## Interface
- WIDTH, 16, operand width; sums are WIDTH+1 bits
- CNT_W, 32, width of sample and error counters
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- num_samples  in  CNT_W  samples per run; sampled when start is accepted
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts a sample this cycle
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- approx_sum  in  WIDTH+1  approximate adder output
- busy  out  1  high in RUN and DRAIN
- done  out  1  high (level) in DONE
- err_count  out  CNT_W  samples with approx_sum != exact sum
- sum_abs_err  out  WIDTH+1+CNT_W  Σ|exact − approx|
- max_abs_err  out  WIDTH+1  largest |exact − approx|
- worst_a, worst_b  out  WIDTH  operands of the first sample that reached max_abs_err

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with start=1:
  - Latch num_samples and clear all accumulators and the accepted count.
  - If num_samples=0, go to DONE; otherwise go to RUN.
- RUN:
  - in_ready = (accepted < num_samples).
  - A sample is accepted when in_valid && in_ready.
  - On the accept that makes accepted == num_samples, go to DRAIN.
  - start is ignored.
- DRAIN: lasts 2 cycles so the pipeline can empty, then go to DONE. start is ignored.
- DONE: outputs are held until start or rst.
- Arithmetic:
  - exact = op_a + op_b, zero-extended to WIDTH+1 bits.
  - abs_err = |exact − approx_sum|, computed in WIDTH+2 bits signed and then truncated to WIDTH+1.
  - The maximum possible abs_err is 2^(WIDTH+1)−1.
  - sum_abs_err is sized so it never overflows; no saturation logic.
- max_abs_err, worst_a and worst_b update only when abs_err is strictly greater than the current max. Ties keep the earlier sample.
- When every sample is exact: max_abs_err=0 and worst_a/worst_b=0.
- rst at any time forces IDLE, all outputs 0, and in_ready=0. Partial results are discarded.

## Timing
- Reset values: in_ready=0, busy=0, done=0, all counters, sums, max and worst values 0.
- Pipeline:
  - Stage 1 registers operands and abs_err at the accept edge t.
  - Stage 2 updates the accumulators at edge t+1.
- Latency from an accept to the accumulators reflecting it: 2 edges.
- Last accept at edge t:
  - in_ready=0 from t.
  - DRAIN covers t..t+2.
  - done=1 and busy=0 from edge t+2, with results final.
- start with num_samples=0: done=1 one edge after start.
- start in RUN: RUN state, latched num_samples and accumulators unchanged.
- No combinational path from in_valid to in_ready; in_ready depends only on registered state.

## Structure
- Package adder_err_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - WIDTH/CNT_W-derived width constants (SUM_W = WIDTH+1, ACC_W = WIDTH+1+CNT_W)
- Sub-module adder_err_calc: purely combinational; computes exact, abs_err, is_err.
  - The top level registers its outputs as stage 1.
  - Keeps the arithmetic reusable for other operand widths.

## Test plan
- num_samples=4, four samples with approx_sum = op_a+op_b → err_count=0, sum_abs_err=0, max_abs_err=0; done 2 edges after 4th accept.
- Single sample a=0x00FF, b=0x0001, approx=0x00000 → err_count=1, sum_abs_err=256, max_abs_err=256, worst_a=0x00FF, worst_b=0x0001.
- Single sample a=0, b=0, approx=0x1FFFF → max_abs_err=131071, sum_abs_err=131071.
- Tie ordering: samples (a=0x10, b=0, approx=0) then (a=0x20, b=0, approx=0x30), both abs_err=16 → max=16, worst_a=0x10, sum=32, err_count=2.
- Backpressure: num_samples=3, in_valid held high for 6 cycles → exactly 3 accepts, in_ready low after the 3rd, sample 4 is ignored.
- Stall and reset:
  - Run with in_valid gaps → results unaffected.
  - rst pulsed mid-RUN → all outputs 0 immediately, state IDLE.
  - A new start then produces correct fresh results.
  - start pulsed during RUN → ignored.
